// File: rtl/count_display_driver.sv
// Binary-to-BCD converter (iterative double-dabble) feeding a multiplexed,
// active-low, 3-digit 7-segment display scanner.
module count_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value_in,
    output logic [11:0] bcd_out,
    output logic        bcd_valid,
    output logic        busy,
    output logic [6:0]  seg_n,
    output logic [2:0]  an_n
);

    localparam int unsigned VAL_W  = 8;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned ITER_W = 3;
    localparam int unsigned PRE_W  = 16;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned AN_W   = 3;

    localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VAL_W - 1);
    localparam logic [SEG_W-1:0]  SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   shreg_q, shreg_d;
    logic [VAL_W-1:0]   cap_q, cap_d;
    logic [VAL_W-1:0]   last_q, last_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [AN_W-1:0]    an_q, an_d;

    logic [BCD_W-1:0]         adj;
    logic [BCD_W+VAL_W-1:0]   shifted;
    logic                     wrap;
    logic [3:0]               digit;
    logic                     blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? 4'(n + 4'd3) : n;
    endfunction

    // Active-high gfedcba glyphs for decimal digits.
    function automatic logic [SEG_W-1:0] glyph(input logic [3:0] d);
        logic [SEG_W-1:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cap_q     <= '0;
            last_q    <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            pre_q     <= '0;
            idx_q     <= '0;
            seg_q     <= 7'h40;
            an_q      <= 3'b110;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cap_q     <= cap_d;
            last_q    <= last_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    // Conversion FSM; the final SHIFT iteration performs the DONE update in place.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cap_d     = cap_q;
        last_d    = last_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;

        adj     = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
        shifted = {adj, shreg_q} << 1;

        case (state_q)
            IDLE: begin
                if (value_in != last_q) begin
                    cap_d     = value_in;
                    shreg_d   = value_in;
                    scratch_d = '0;
                    iter_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[BCD_W+VAL_W-1:VAL_W];
                shreg_d   = shifted[VAL_W-1:0];
                iter_d    = ITER_W'(iter_q + 3'd1);
                if (iter_q == ITER_LAST) begin
                    bcd_d   = shifted[BCD_W+VAL_W-1:VAL_W];
                    last_d  = cap_q;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Display scan: segments and anodes are both derived from the next index.
    always_comb begin
        wrap  = (pre_q == PRE_MAX);
        pre_d = wrap ? '0 : PRE_W'(pre_q + 16'd1);
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == 2'd2) ? '0 : IDX_W'(idx_q + 2'd1);
        end

        digit = 4'd0;
        blank = 1'b0;
        an_d  = 3'b111;
        case (idx_d)
            2'd0: begin
                digit = bcd_q[3:0];
                an_d  = 3'b110;
            end
            2'd1: begin
                digit = bcd_q[7:4];
                blank = BLANK_LZ && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                an_d  = 3'b101;
            end
            2'd2: begin
                digit = bcd_q[11:8];
                blank = BLANK_LZ && (bcd_q[11:8] == 4'd0);
                an_d  = 3'b011;
            end
            default: begin
                blank = 1'b1;
                an_d  = 3'b111;
            end
        endcase

        seg_d = blank ? SEG_BLANK : ~glyph(digit);
    end

    assign bcd_out   = bcd_q;
    assign bcd_valid = valid_q;
    assign busy      = busy_q;
    assign seg_n     = seg_q;
    assign an_n      = an_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver: reset state, conversion latency,
// BCD results, scan/blanking, mid-conversion value change and reset.
module tb_count_display_driver;

    logic        clk;
    logic        reset;
    logic [7:0]  value_in;
    logic [11:0] bcd_out;
    logic        bcd_valid;
    logic        busy;
    logic [6:0]  seg_n;
    logic [2:0]  an_n;

    int checks = 0;
    int errors = 0;

    count_display_driver #(
        .REFRESH_DIV(4),
        .BLANK_LZ   (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .bcd_out  (bcd_out),
        .bcd_valid(bcd_valid),
        .busy     (busy),
        .seg_n    (seg_n),
        .an_n     (an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bcd"},   bcd_out, 12'h000);
        check({tag, "_valid"}, 12'(bcd_valid), 12'd0);
        check({tag, "_busy"},  12'(busy), 12'd0);
        check({tag, "_an"},    12'(an_n), 12'(3'b110));
        check({tag, "_seg"},   12'(seg_n), 12'(7'h40));
    endtask

    // Called at a negedge; value_in already holds v unless drive is set.
    task automatic run_conv(input logic [7:0] v, input logic [11:0] exp, input bit drive);
        bit seen;
        if (drive) value_in = v;
        @(negedge clk);
        check("busy_after_capture", 12'(busy), 12'd1);
        check("valid_at_capture", 12'(bcd_valid), 12'd0);
        seen = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (bcd_valid) seen = 1'b1;
        end
        check("valid_early", 12'(seen), 12'd0);
        @(negedge clk);
        check("valid_pulse", 12'(bcd_valid), 12'd1);
        check("busy_done", 12'(busy), 12'd0);
        check("bcd_result", bcd_out, exp);
        @(negedge clk);
        check("valid_one_cycle", 12'(bcd_valid), 12'd0);
    endtask

    // Aligns to the start of the ones phase, then checks 4 cycles per digit.
    task automatic check_scan(input logic [6:0] s_ones, input logic [6:0] s_tens,
                              input logic [6:0] s_hund);
        logic [2:0] an_exp [3];
        logic [6:0] seg_exp [3];
        int n;
        an_exp[0]  = 3'b110;
        an_exp[1]  = 3'b101;
        an_exp[2]  = 3'b011;
        seg_exp[0] = s_ones;
        seg_exp[1] = s_tens;
        seg_exp[2] = s_hund;
        n = 0;
        while (an_n !== 3'b011 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("scan_find_hund", 12'(an_n), 12'(3'b011));
        n = 0;
        while (an_n !== 3'b110 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("scan_find_ones", 12'(an_n), 12'(3'b110));
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) begin
                check("scan_an", 12'(an_n), 12'(an_exp[d]));
                check("scan_seg", 12'(seg_n), 12'(seg_exp[d]));
                @(negedge clk);
            end
        end
        check("scan_wrap_ones", 12'(an_n), 12'(3'b110));
    endtask

    initial begin
        bit seen;
        reset    = 1'b1;
        value_in = 8'd0;

        // Reset and idle with value 0.
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bcd_valid || busy) seen = 1'b1;
        end
        check("idle_no_conv", 12'(seen), 12'd0);
        check("idle_bcd", bcd_out, 12'h000);

        // Max value and sweep.
        run_conv(8'd255, 12'h255, 1'b1);
        run_conv(8'd9,   12'h009, 1'b1);
        run_conv(8'd10,  12'h010, 1'b1);
        run_conv(8'd99,  12'h099, 1'b1);
        run_conv(8'd100, 12'h100, 1'b1);
        run_conv(8'd128, 12'h128, 1'b1);
        check_scan(7'h00, 7'h24, 7'h79);
        run_conv(8'd200, 12'h200, 1'b1);
        run_conv(8'd7,   12'h007, 1'b1);
        check_scan(7'h78, 7'h7F, 7'h7F);

        // Value change during SHIFT is deferred to the next conversion.
        value_in = 8'd50;
        @(negedge clk);
        check("t5_busy", 12'(busy), 12'd1);
        repeat (2) @(negedge clk);
        value_in = 8'd51;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bcd_valid) seen = 1'b1;
        end
        check("t5_valid_early", 12'(seen), 12'd0);
        @(negedge clk);
        check("t5_valid_first", 12'(bcd_valid), 12'd1);
        check("t5_bcd_first", bcd_out, 12'h050);
        run_conv(8'd51, 12'h051, 1'b0);

        // Reset in the middle of a conversion.
        value_in = 8'd200;
        @(negedge clk);
        check("t6_busy", 12'(busy), 12'd1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        check_reset_state("midrst_hold");
        reset = 1'b0;
        run_conv(8'd200, 12'h200, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
Downstream display stage for the 8-bit smart counter. It consumes the counter's 8-bit count value and converts it to 3-digit BCD with an iterative shift-add-3 (double-dabble) FSM. It then drives a time-multiplexed, active-low, 3-digit 7-segment display. It also exports the registered BCD value and a conversion-done strobe for other consumers.

Parameters:
REFRESH_DIV, 16'd50000, number of clk cycles each digit stays enabled; legal range 1..65535.
BLANK_LZ, 1, 1 = blank leading zeros (hundreds, and tens when hundreds is zero); 0 = show all digits.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
value_in  input  8  binary count value from the counter's count output.
bcd_out  output  12  registered BCD result: [11:8] hundreds, [7:4] tens, [3:0] ones.
bcd_valid  output  1  one-cycle pulse when bcd_out is updated.
busy  output  1  high while a conversion is in progress.
seg_n  output  7  active-low segments; bit0=a … bit6=g.
an_n  output  3  active-low digit enables; bit0=ones, bit1=tens, bit2=hundreds.

Behaviour:
- Single clock domain. reset is asynchronous, active-high.
- Reset values:
  - FSM in IDLE; bcd_out=12'h000; last_value=0; bcd_valid=0; busy=0.
  - Digit index=0; prescaler=0; an_n=3'b110; seg_n=7'h40 (glyph "0").
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on each edge, if value_in != last_value, capture value_in into an 8-bit shift register, clear the 12-bit BCD scratch and the iteration counter, set busy=1, go to SHIFT. Capture edge = E0.
  - SHIFT: each edge E1..E8 performs one iteration. For each scratch nibble >= 5, add 3. Then shift {scratch, shreg} left by 1. After the 8th iteration (E8), go to DONE.
  - DONE (the E8 update itself): bcd_out <= scratch; last_value <= captured value; bcd_valid=1 for the following cycle only; busy=0; state returns to IDLE.
  - Latency: 8 edges from the capture edge to bcd_out updated.
- value_in changes during SHIFT are ignored. IDLE re-compares on the edge after E8; a differing value starts a new conversion there.
- No conversion runs after reset while value_in=0 (last_value already 0).
- Arithmetic: output range 000..255. Nibbles never exceed 9 after an iteration. Nothing is truncated.
- Display scan:
  - The prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→2→0.
  - an_n and seg_n are both registered every clock from the next index and the current bcd_out. They change on the same edge (no ghosting).
  - seg_n reflects a new bcd_out one cycle after the bcd_out update.
- Glyphs (active-high gfedcba, then inverted onto seg_n): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Blank = seg_n 7'h7F.
- Leading-zero blanking (BLANK_LZ=1):
  - Hundreds digit blank if its nibble is 0.
  - Tens digit blank if both hundreds and tens nibbles are 0.
  - Ones digit is never blanked.
- Reset mid-conversion: immediate return to reset values; no bcd_valid pulse; the interrupted value is converted after release if it differs from 0.
- REFRESH_DIV=1: digit index advances every cycle.

Test Plan:
1. Assert reset, then release with value_in=0 → an_n=3'b110, seg_n=7'h40, bcd_out=12'h000, busy=0, no bcd_valid in 20 cycles.
2. value_in 0→255 → busy=1 after the capture edge, bcd_valid pulses once 8 edges later, bcd_out=12'h255, busy=0 in the same cycle.
3. Sweep value_in 9, 10, 99, 100, 128, 200, each held until bcd_valid → bcd_out=009, 010, 099, 100, 128, 200 respectively.
4. REFRESH_DIV=4, value 128 → an_n cycles 110→101→011 every 4 cycles; seg_n=0x00 (ones "8"), 0x24 (tens "2"), 0x79 (hundreds "1"). Value 7 → seg_n=0x78 (ones), 0x7F (tens), 0x7F (hundreds).
5. value_in=50, then 51 on the 3rd SHIFT cycle → first bcd_out=050 with bcd_valid, then a second conversion starts on the next edge and gives bcd_out=051 with a second bcd_valid.
6. value_in=200, reset pulsed on the 4th SHIFT cycle → outputs return immediately to reset values, no bcd_valid; after release, bcd_out=200 eight edges after the new capture edge.
